// File: rtl/dds_phase_gen_if.sv
// dds_phase_gen_if: control inputs and LUT-side outputs of the DDS phase generator
interface dds_phase_gen_if #(
   parameter int PW = 32,
   parameter int AW = 10
);
   logic          tick;
   logic          start;
   logic          stop;
   logic [PW-1:0] ftw_in;
   logic          ftw_load;
   logic [PW-1:0] phase_offset;
   logic [AW-1:0] lut_addr;
   logic          lut_rd_en;
   logic [1:0]    quadrant;
   logic          sample_valid;
   logic          busy;

   modport master (
      output tick, start, stop, ftw_in, ftw_load, phase_offset,
      input  lut_addr, lut_rd_en, quadrant, sample_valid, busy
   );

   modport slave (
      input  tick, start, stop, ftw_in, ftw_load, phase_offset,
      output lut_addr, lut_rd_en, quadrant, sample_valid, busy
   );
endinterface

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase accumulator with quarter-sine LUT addressing and quadrant pipeline
module dds_phase_gen #(
   parameter int PW      = 32,
   parameter int AW      = 10,
   parameter int LUT_LAT = 1
) (
   input logic              clk,
   input logic              reset_n,
   dds_phase_gen_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   state_t                   state_q;
   logic [PW-1:0]            acc_q, acc_d;
   logic [PW-1:0]            ftw_act_q, ftw_pend_q, ftw_eff;
   logic                     pend_q;
   logic [AW-1:0]            lut_addr_q, addr_d;
   logic                     lut_rd_en_q;
   logic [1:0]               quad_q;
   logic [LUT_LAT-1:0]       vld_pipe_q;
   logic [LUT_LAT-1:0][1:0]  quad_pipe_q;
   logic [AW+1:0]            p_top;
   logic                     carry, ftw_zero, step;

   // a pending tuning word takes effect on the very update that consumes it
   assign ftw_eff  = pend_q ? ftw_pend_q : ftw_act_q;
   assign ftw_zero = (ftw_eff == '0);
   assign {carry, acc_d} = {1'b0, acc_q} + {1'b0, ftw_eff};
   // only the quadrant and LUT index bits of the effective phase matter
   assign p_top  = (AW+2)'((acc_q + bus.phase_offset) >> (PW-2-AW));
   assign addr_d = p_top[AW] ? ~p_top[AW-1:0] : p_top[AW-1:0];
   assign step   = bus.tick && (state_q == RUN || (state_q == STOPPING && !ftw_zero));

   // control FSM, accumulator, tuning-word staging and LUT address register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ftw_act_q   <= '0;
         ftw_pend_q  <= '0;
         pend_q      <= 1'b0;
         lut_addr_q  <= '0;
         lut_rd_en_q <= 1'b0;
         quad_q      <= '0;
      end else begin
         lut_rd_en_q <= step;
         if (step) begin
            lut_addr_q <= addr_d;
            quad_q     <= p_top[AW+1:AW];
         end
         if (pend_q && (step || state_q == IDLE)) begin
            ftw_act_q <= ftw_pend_q;
            pend_q    <= 1'b0;
         end
         if (bus.ftw_load) begin
            ftw_pend_q <= bus.ftw_in;
            pend_q     <= 1'b1;
         end
         case (state_q)
            IDLE: if (bus.start) begin
               state_q <= RUN;
               acc_q   <= '0;
            end
            RUN: begin
               if (step) acc_q <= acc_d;
               if (bus.stop) state_q <= STOPPING;
            end
            STOPPING: if (ftw_zero || (step && carry)) begin
               state_q <= IDLE;
               acc_q   <= '0;
            end else if (step) acc_q <= acc_d;
            default: state_q <= IDLE;
         endcase
      end
   end

   // align quadrant and valid with LUT data; keeps draining after IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe_q  <= '0;
         quad_pipe_q <= '0;
      end else begin
         vld_pipe_q[0]  <= lut_rd_en_q;
         quad_pipe_q[0] <= quad_q;
         for (int i = 1; i < LUT_LAT; i++) begin
            vld_pipe_q[i]  <= vld_pipe_q[i-1];
            quad_pipe_q[i] <= quad_pipe_q[i-1];
         end
      end
   end

   assign bus.lut_addr     = lut_addr_q;
   assign bus.lut_rd_en    = lut_rd_en_q;
   assign bus.quadrant     = quad_pipe_q[LUT_LAT-1];
   assign bus.sample_valid = vld_pipe_q[LUT_LAT-1];
   assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: directed vectors for the DDS phase generator
module tb_dds_phase_gen;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   dds_phase_gen_if #(.PW(32), .AW(10)) bus ();
   dds_phase_gen #(.PW(32), .AW(10), .LUT_LAT(1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, " addr"},  32'(bus.lut_addr), 0);
      chk({tag, " rd"},    32'(bus.lut_rd_en), 0);
      chk({tag, " quad"},  32'(bus.quadrant), 0);
      chk({tag, " valid"}, 32'(bus.sample_valid), 0);
      chk({tag, " busy"},  32'(bus.busy), 0);
   endtask

   initial begin
      bus.tick = 0; bus.start = 0; bus.stop = 0;
      bus.ftw_in = 0; bus.ftw_load = 0; bus.phase_offset = 0;
      #2 reset_n = 0;
      @(negedge clk);
      outs_zero("reset");
      cyc();
      reset_n = 1;
      // quarter-turn tuning word, tick every cycle
      bus.ftw_in = 32'h4000_0000; bus.ftw_load = 1;
      cyc();
      bus.ftw_load = 0; bus.start = 1; bus.tick = 1;
      cyc();
      bus.start = 0;
      chk("run busy", 32'(bus.busy), 1);
      chk("run no rd yet", 32'(bus.lut_rd_en), 0);
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("seq addr", 32'(bus.lut_addr), (k % 2) ? 1023 : 0);
         chk("seq rd", 32'(bus.lut_rd_en), 1);
         if (k > 0) begin
            chk("seq quad", 32'(bus.quadrant), (k - 1) % 4);
            chk("seq valid", 32'(bus.sample_valid), 1);
         end
      end
      chk("wrap keeps run", 32'(bus.busy), 1);
      // stop after a quadrant-1 sample: quadrants 2 and 3 still emitted
      bus.stop = 1;
      cyc();
      bus.stop = 0;
      chk("stop busy", 32'(bus.busy), 1);
      chk("stop q2 addr", 32'(bus.lut_addr), 0);
      chk("stop quad1", 32'(bus.quadrant), 1);
      cyc();
      chk("stop idle", 32'(bus.busy), 0);
      chk("stop q3 addr", 32'(bus.lut_addr), 1023);
      chk("stop q3 rd", 32'(bus.lut_rd_en), 1);
      chk("stop quad2", 32'(bus.quadrant), 2);
      cyc();
      chk("drain rd", 32'(bus.lut_rd_en), 0);
      chk("drain valid", 32'(bus.sample_valid), 1);
      chk("drain quad3", 32'(bus.quadrant), 3);
      cyc();
      chk("drained valid", 32'(bus.sample_valid), 0);
      chk("idle addr hold", 32'(bus.lut_addr), 1023);
      // restart begins from phase 0
      bus.start = 1;
      cyc();
      bus.start = 0;
      cyc();
      chk("restart addr", 32'(bus.lut_addr), 0);
      chk("restart rd", 32'(bus.lut_rd_en), 1);
      // tick every 4th cycle
      for (int r = 0; r < 2; r++) begin
         bus.tick = 0;
         for (int j = 0; j < 3; j++) begin
            cyc();
            chk("gap rd", 32'(bus.lut_rd_en), 0);
            chk("gap addr hold", 32'(bus.lut_addr), r ? 1023 : 0);
         end
         bus.tick = 1;
         cyc();
         chk("tick rd", 32'(bus.lut_rd_en), 1);
         chk("tick addr", 32'(bus.lut_addr), r ? 0 : 1023);
      end
      bus.tick = 0; bus.stop = 1;
      cyc();
      bus.stop = 0;
      chk("stopping no tick", 32'(bus.busy), 1);
      bus.tick = 1;
      cyc();
      chk("last q3 addr", 32'(bus.lut_addr), 1023);
      chk("last idle", 32'(bus.busy), 0);
      cyc();
      chk("idle tick ignored", 32'(bus.lut_rd_en), 0);
      // phase offset of a quarter turn
      bus.phase_offset = 32'h4000_0000; bus.start = 1;
      cyc();
      bus.start = 0;
      cyc();
      chk("offset first addr", 32'(bus.lut_addr), 1023);
      bus.stop = 1;
      cyc();
      bus.stop = 0;
      chk("offset quad1", 32'(bus.quadrant), 1);
      chk("offset valid", 32'(bus.sample_valid), 1);
      chk("offset p2 addr", 32'(bus.lut_addr), 0);
      cyc();
      chk("offset p3 addr", 32'(bus.lut_addr), 1023);
      chk("offset still busy", 32'(bus.busy), 1);
      cyc();
      chk("offset carry addr", 32'(bus.lut_addr), 0);
      chk("offset carry rd", 32'(bus.lut_rd_en), 1);
      chk("offset carry idle", 32'(bus.busy), 0);
      cyc();
      chk("offset last quad", 32'(bus.quadrant), 0);
      bus.phase_offset = 0;
      // zero tuning word: start, stop, idle without samples
      bus.tick = 0; bus.ftw_in = 0; bus.ftw_load = 1;
      cyc();
      bus.ftw_load = 0;
      cyc();
      bus.start = 1;
      cyc();
      bus.start = 0; bus.stop = 1;
      cyc();
      bus.stop = 0; bus.tick = 1;
      chk("zero stopping busy", 32'(bus.busy), 1);
      chk("zero no rd", 32'(bus.lut_rd_en), 0);
      cyc();
      chk("zero idle", 32'(bus.busy), 0);
      chk("zero no rd2", 32'(bus.lut_rd_en), 0);
      chk("zero no valid", 32'(bus.sample_valid), 0);
      cyc();
      chk("zero no valid2", 32'(bus.sample_valid), 0);
      // start and stop together in IDLE enter RUN
      bus.tick = 0; bus.ftw_in = 32'h4000_0000; bus.ftw_load = 1;
      cyc();
      bus.ftw_load = 0;
      cyc();
      bus.start = 1; bus.stop = 1;
      cyc();
      bus.start = 0; bus.stop = 0;
      chk("start+stop busy", 32'(bus.busy), 1);
      bus.tick = 1;
      repeat (6) cyc();
      chk("start+stop is run", 32'(bus.busy), 1);
      chk("run 6th addr", 32'(bus.lut_addr), 1023);
      chk("pending rd", 32'(bus.lut_rd_en), 1);
      // asynchronous reset with a sample in flight
      #1 reset_n = 0;
      #1 outs_zero("async rst");
      cyc();
      reset_n = 1;
      for (int j = 0; j < 4; j++) begin
         cyc();
         chk("post rst valid", 32'(bus.sample_valid), 0);
         chk("post rst busy", 32'(bus.busy), 0);
         chk("post rst rd", 32'(bus.lut_rd_en), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
